// File: rtl/hdmi_pkg.sv
// Shared timing sets, flag bundle and helpers for the HDMI timing front end.
package hdmi_pkg;

    localparam int HDMI_COORD_W   = 12;
    localparam int HDMI_MAX_TOTAL = 1 << HDMI_COORD_W;

    typedef struct packed {
        int h_active;
        int h_front;
        int h_sync;
        int h_back;
        int v_active;
        int v_front;
        int v_sync;
        int v_back;
    } hdmi_timing_t;

    localparam hdmi_timing_t TIMING_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam hdmi_timing_t TIMING_1280X720_60 = '{1280, 110, 40, 220, 720, 5, 5, 20};

    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
    } hdmi_flags_t;

    // One extra bit so window ends equal to the full 4096 range still compare correctly.
    function automatic logic in_window(input logic [HDMI_COORD_W:0] pos,
                                       input logic [HDMI_COORD_W:0] lo,
                                       input logic [HDMI_COORD_W:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/hdmi_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
module hdmi_delay
    import hdmi_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr_low,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!clr_low) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/hdmi_timing.sv
// Video timing generator: issues fetch coordinates and realigns flags with the
// pixel returned by a fixed-latency source before handing them to hdmi_encode.
module hdmi_timing
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE   = TIMING_640X480_60.h_active,
    parameter int H_FRONT    = TIMING_640X480_60.h_front,
    parameter int H_SYNC     = TIMING_640X480_60.h_sync,
    parameter int H_BACK     = TIMING_640X480_60.h_back,
    parameter int V_ACTIVE   = TIMING_640X480_60.v_active,
    parameter int V_FRONT    = TIMING_640X480_60.v_front,
    parameter int V_SYNC     = TIMING_640X480_60.v_sync,
    parameter int V_BACK     = TIMING_640X480_60.v_back,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset_low,
    output logic [HDMI_COORD_W-1:0] fetch_x,
    output logic [HDMI_COORD_W-1:0] fetch_y,
    output logic                    fetch_valid,
    output logic                    line_start,
    output logic                    frame_start,
    input  logic [23:0]             rgb_in,
    output logic                    active,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic [23:0]             rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > HDMI_MAX_TOTAL || V_TOTAL > HDMI_MAX_TOTAL || LATENCY < 1) begin : g_bad_cfg
        $error("hdmi_timing: totals must fit in 4096 and LATENCY must be at least 1");
    end

    localparam logic [HDMI_COORD_W-1:0] H_LAST   = HDMI_COORD_W'(H_TOTAL - 1);
    localparam logic [HDMI_COORD_W-1:0] V_LAST   = HDMI_COORD_W'(V_TOTAL - 1);
    localparam logic [HDMI_COORD_W:0]   H_ACT_W  = (HDMI_COORD_W+1)'(H_ACTIVE);
    localparam logic [HDMI_COORD_W:0]   V_ACT_W  = (HDMI_COORD_W+1)'(V_ACTIVE);
    localparam logic [HDMI_COORD_W:0]   HS_START = (HDMI_COORD_W+1)'(H_ACTIVE + H_FRONT);
    localparam logic [HDMI_COORD_W:0]   HS_END   = (HDMI_COORD_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HDMI_COORD_W:0]   VS_START = (HDMI_COORD_W+1)'(V_ACTIVE + V_FRONT);
    localparam logic [HDMI_COORD_W:0]   VS_END   = (HDMI_COORD_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [HDMI_COORD_W-1:0] h_q, h_d;
    logic [HDMI_COORD_W-1:0] v_q, v_d;
    hdmi_flags_t             raw_flags;
    hdmi_flags_t             tail_flags;
    logic                    active_q, active_d;
    logic                    h_sync_q, h_sync_d;
    logic                    v_sync_q, v_sync_d;
    logic [23:0]             rgb_q, rgb_d;

    always_comb begin
        h_d = h_q + HDMI_COORD_W'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + HDMI_COORD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign fetch_x     = h_q;
    assign fetch_y     = v_q;
    assign fetch_valid = in_window({1'b0, h_q}, '0, H_ACT_W) && in_window({1'b0, v_q}, '0, V_ACT_W);
    assign line_start  = (h_q == '0);
    assign frame_start = (h_q == '0) && (v_q == '0);

    // vs depends only on v, so it naturally changes on line boundaries.
    always_comb begin
        raw_flags.valid = fetch_valid;
        raw_flags.hs    = in_window({1'b0, h_q}, HS_START, HS_END);
        raw_flags.vs    = in_window({1'b0, v_q}, VS_START, VS_END);
    end

    hdmi_delay #(
        .WIDTH ($bits(hdmi_flags_t)),
        .DEPTH (LATENCY)
    ) u_flag_delay (
        .clk     (clk),
        .clr_low (reset_low),
        .d       (raw_flags),
        .q       (tail_flags)
    );

    always_comb begin
        active_d = tail_flags.valid;
        h_sync_d = tail_flags.hs ? H_SYNC_POL : ~H_SYNC_POL;
        v_sync_d = tail_flags.vs ? V_SYNC_POL : ~V_SYNC_POL;
        rgb_d    = tail_flags.valid ? rgb_in : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            active_q <= 1'b0;
            h_sync_q <= ~H_SYNC_POL;
            v_sync_q <= ~V_SYNC_POL;
            rgb_q    <= '0;
        end else begin
            active_q <= active_d;
            h_sync_q <= h_sync_d;
            v_sync_q <= v_sync_d;
            rgb_q    <= rgb_d;
        end
    end

    assign active = active_q;
    assign h_sync = h_sync_q;
    assign v_sync = v_sync_q;
    assign rgb    = rgb_q;

endmodule
